// File: rtl/keypad_time_decoder.sv
// keypad_time_decoder
// Receive side of the keypad encoder. In entry mode, debounced key digits
// shift into an M:SS BCD time register. In count mode, the register
// decrements once per 1 Hz tick and pulses done on reaching 0:00.
module keypad_time_decoder #(
    parameter int SEC_TENS_MAX = 5,
    parameter int MAX_DIGIT    = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] D,
    input  logic       load,
    input  logic       pgt_1Hz,
    input  logic       en,
    input  logic       clear_time,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       active,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] C_SEC_TENS_MAX = 4'(SEC_TENS_MAX);
    localparam logic [3:0] C_MAX_DIGIT    = 4'(MAX_DIGIT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_pgt_d;
    logic [3:0] r_mins;
    logic [3:0] r_sec_tens;
    logic [3:0] r_sec_ones;
    logic       r_done;

    logic       w_edge;
    logic       w_zero;
    logic       w_key_ok;
    logic [3:0] w_dec_mins;
    logic [3:0] w_dec_sec_tens;
    logic [3:0] w_dec_sec_ones;
    logic       w_dec_zero;
    logic [3:0] w_mins_nxt;
    logic [3:0] w_sec_tens_nxt;
    logic [3:0] w_sec_ones_nxt;
    logic       w_done_nxt;

    // pgt_d resets high, so a strobe already high at reset release is not an edge
    assign w_edge   = pgt_1Hz & ~r_pgt_d;
    assign w_zero   = (r_mins == 4'd0) && (r_sec_tens == 4'd0) && (r_sec_ones == 4'd0);
    assign w_key_ok = ~load && (D <= C_MAX_DIGIT);

    // One-second BCD decrement with borrow; tens above SEC_TENS_MAX count down as entered
    always_comb begin
        w_dec_mins     = r_mins;
        w_dec_sec_tens = r_sec_tens;
        w_dec_sec_ones = r_sec_ones - 4'd1;
        if (r_sec_ones == 4'd0) begin
            w_dec_sec_ones = 4'd9;
            if (r_sec_tens != 4'd0) begin
                w_dec_sec_tens = r_sec_tens - 4'd1;
            end else begin
                w_dec_sec_tens = C_SEC_TENS_MAX;
                w_dec_mins     = r_mins - 4'd1;
            end
        end
        w_dec_zero = (w_dec_mins == 4'd0) && (w_dec_sec_tens == 4'd0) &&
                     (w_dec_sec_ones == 4'd0);
    end

    // Next state, next time digits and done pulse; clear_time overrides everything
    always_comb begin
        w_state_nxt    = r_state;
        w_mins_nxt     = r_mins;
        w_sec_tens_nxt = r_sec_tens;
        w_sec_ones_nxt = r_sec_ones;
        w_done_nxt     = 1'b0;
        if (clear_time) begin
            w_state_nxt    = ST_ENTRY;
            w_mins_nxt     = 4'd0;
            w_sec_tens_nxt = 4'd0;
            w_sec_ones_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (w_edge && w_key_ok) begin
                        w_mins_nxt     = r_sec_tens;
                        w_sec_tens_nxt = r_sec_ones;
                        w_sec_ones_nxt = D;
                    end
                    if (en && !w_zero) begin
                        w_state_nxt = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    // Pause beats a coincident tick: the tick is dropped
                    if (!en) begin
                        w_state_nxt = ST_ENTRY;
                    end else if (w_edge) begin
                        w_mins_nxt     = w_dec_mins;
                        w_sec_tens_nxt = w_dec_sec_tens;
                        w_sec_ones_nxt = w_dec_sec_ones;
                        if (w_dec_zero) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!en) begin
                        w_state_nxt = ST_ENTRY;
                    end
                end
                default: begin
                    w_state_nxt = ST_ENTRY;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ENTRY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Time digits, strobe delay and done pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pgt_d    <= 1'b1;
            r_mins     <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
            r_done     <= 1'b0;
        end else begin
            r_pgt_d    <= pgt_1Hz;
            r_mins     <= w_mins_nxt;
            r_sec_tens <= w_sec_tens_nxt;
            r_sec_ones <= w_sec_ones_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign mins     = r_mins;
    assign sec_tens = r_sec_tens;
    assign sec_ones = r_sec_ones;
    assign zero     = w_zero;
    assign active   = (r_state == ST_COUNT);
    assign done     = r_done;

endmodule

// File: doc/keypad_time_decoder.md
Name: keypad_time_decoder

Overview:
- Receiving end of the keypad encoder interface; consumes `D`, `load` and `pgt_1Hz` from the encoder.
- In entry mode (`en`=0) it shifts debounced key digits into a BCD time register of the form M:SS.
- In count mode (`en`=1) it decrements that register once per 1 Hz tick and flags completion.
- Its outputs feed the display driver and the magnetron/door control logic.

Parameters:
- SEC_TENS_MAX, 5, value loaded into the seconds-tens digit on a minute borrow.
- MAX_DIGIT, 9, largest accepted key digit; keys with D > MAX_DIGIT are ignored.

Ports:
- clk  input  1  system clock (same clock as the encoder).
- rst_n  input  1  asynchronous active-low reset.
- D  input  4  key digit from the encoder, valid while load=0.
- load  input  1  encoder "no key pressed" flag; 1 = no key, 0 = key held.
- pgt_1Hz  input  1  encoder strobe:
  - debounced key level when en=0;
  - one-cycle 1 Hz tick when en=1.
- en  input  1  mode: 0 = entry, 1 = count. Same signal drives the encoder mux select.
- clear_time  input  1  synchronous clear of time (clear key).
- mins  output  4  minutes digit, BCD 0-9.
- sec_tens  output  4  seconds-tens digit, BCD.
- sec_ones  output  4  seconds-ones digit, BCD.
- zero  output  1  1 when all three digits are 0 (combinational from the registers).
- active  output  1  1 while the state is COUNT.
- done  output  1  one-cycle pulse on reaching 0:00.

Behaviour:
- Reset (rst_n=0, async):
  - mins, sec_tens, sec_ones = 0; state = ENTRY; done = 0; active = 0.
  - pgt_d (registered copy of pgt_1Hz) resets to 1, so a strobe already high at reset release is not treated as an edge.
- Edge detect: edge = pgt_1Hz & ~pgt_d, evaluated each clk. pgt_d <= pgt_1Hz every cycle.
- Register writes happen on the clk edge that samples edge=1. New digits are visible one cycle after pgt_1Hz first samples high.
- Priority per cycle: clear_time > mode action.
  - clear_time=1: all digits = 0, state = ENTRY, done = 0. Any edge in the same cycle is discarded.
- State ENTRY:
  - On edge with load=0 and D <= MAX_DIGIT, shift left: mins <= sec_tens, sec_tens <= sec_ones, sec_ones <= D. The old mins value is discarded.
  - Edge with load=1 (key already released) or D > MAX_DIGIT: no change.
  - en=1 and zero=0: go to COUNT next cycle.
  - en=1 and zero=1: remain in ENTRY.
- State COUNT (active=1):
  - On edge, BCD decrement:
    - sec_ones > 0: sec_ones - 1;
    - else if sec_tens > 0: sec_tens - 1, sec_ones = 9;
    - else: mins - 1, sec_tens = SEC_TENS_MAX, sec_ones = 9.
  - Entered seconds-tens values above SEC_TENS_MAX (e.g. 0:99) are not normalised; they count down arithmetically from the entered value.
  - If the decrement produces 0:00: go to DONE; done = 1 for exactly the next cycle.
  - en=0 (pause): go to ENTRY with time retained, no decrement that cycle. Subsequent key digits shift onto the retained time.
- State DONE:
  - done returns to 0 after one cycle; digits hold 0:00; edges are ignored.
  - en=0: go to ENTRY.
- Mid-operation: reset or clear_time during COUNT aborts immediately and never produces a done pulse.
- Simultaneous: en falling on the same cycle as a tick edge means pause wins and the tick is lost.

Test Plan:
- Reset with pgt_1Hz held at 1, release rst_n -> digits 0:00, no capture; state ENTRY, zero=1.
- Entry: keys 1, 3, 0 (each D valid with load=0, pgt level rising) -> after the third key mins=1, sec_tens=3, sec_ones=0. A fourth key 7 -> 3:07 (mins 1 dropped).
- Count: load 1:00, en=1, one tick pulse every 100 clk -> 0:59 after the first tick, 0:50 after the tenth, 0:00 after the 60th. done high exactly one cycle, active=0 afterwards.
- Pause/resume: 0:05 counting, drop en after 2 ticks -> 0:03 held. Key 4 -> 0:34. en=1 -> counts from 0:34.
- clear_time asserted in the same cycle as a tick at 0:01 -> 0:00, no done pulse, state ENTRY.
- en=1 with 0:00 -> stays ENTRY, active=0. Edge with load=1 or D=12 in entry -> digits unchanged.
